// File: rtl/softex_tcdm_responder.sv
// softex_tcdm_responder: TCDM scratchpad target with byte-enabled writes, in-order read FIFO and LFSR grant stalls.
module softex_tcdm_responder #(
  parameter int DW = 128,
  parameter int AW = 32,
  parameter int DEPTH = 4096,
  parameter int RESP_DEPTH = 4,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            stall_en_i,
  input  logic [3:0]                      stall_thr_i,
  input  logic                            req_i,
  output logic                            gnt_o,
  input  logic [AW-1:0]                   add_i,
  input  logic                            wen_i,
  input  logic [DW/8-1:0]                 be_i,
  input  logic [DW-1:0]                   data_i,
  output logic [DW-1:0]                   r_data_o,
  output logic                            r_valid_o,
  input  logic                            r_ready_i,
  output logic [$clog2(RESP_DEPTH+1)-1:0] n_out_o
);
  localparam int OFF = $clog2(DW/8);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(RESP_DEPTH+1);
  localparam int PW = RESP_DEPTH > 1 ? $clog2(RESP_DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, FULL} state_t;
  state_t state;
  logic [15:0] lfsr;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] fifo [RESP_DEPTH];
  logic [PW-1:0] rptr, wptr;
  logic [IW-1:0] idx;
  logic [CW-1:0] n_nxt;
  logic stall, pop, push, wr;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH-1)) ? '0 : p + 1'b1;
  endfunction
  assign idx = add_i[OFF +: IW];
  assign stall = stall_en_i & (lfsr[3:0] < stall_thr_i);
  assign pop = r_valid_o & r_ready_i;
  // a pop in the same cycle frees a credit, so FULL only blocks when nothing leaves
  assign gnt_o = req_i & ~stall & ~rst_i & (~wen_i | (state != FULL) | pop);
  assign push = gnt_o & wen_i;
  assign wr = gnt_o & ~wen_i;
  assign n_nxt = n_out_o + CW'(push) - CW'(pop);
  assign r_valid_o = state != IDLE;
  assign r_data_o = r_valid_o ? fifo[rptr] : '0;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr <= STALL_SEED;
      state <= IDLE;
      n_out_o <= '0;
      rptr <= '0;
      wptr <= '0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      n_out_o <= n_nxt;
      state <= n_nxt == '0 ? IDLE : n_nxt == CW'(RESP_DEPTH) ? FULL : BUSY;
      if (pop) rptr <= inc(rptr);
      if (push) wptr <= inc(wptr);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) fifo[wptr] <= mem[idx];
    for (int b = 0; b < DW/8; b++)
      if (wr & be_i[b]) mem[idx][8*b +: 8] <= data_i[8*b +: 8];
  end
endmodule

// File: tb/tb_softex_tcdm_responder.sv
// tb_softex_tcdm_responder: directed and random checks of the TCDM responder against a queue/array reference model.
module tb_softex_tcdm_responder;
  localparam logic [15:0] SEED = 16'hACE1;
  logic clk, rst, stall_en, req, gnt, wen, r_valid, r_ready;
  logic [3:0] stall_thr;
  logic [31:0] add;
  logic [15:0] be;
  logic [127:0] data, r_data, s_data, saved;
  logic [2:0] n_out;
  logic s_valid;
  logic [127:0] mm [4096];
  logic [127:0] q [$];
  logic [15:0] lm;
  bit eg, rnd_ready;
  int checks, errors, stalls, reqs, n, g;

  softex_tcdm_responder dut (
    .clk_i(clk), .rst_i(rst), .stall_en_i(stall_en), .stall_thr_i(stall_thr),
    .req_i(req), .gnt_o(gnt), .add_i(add), .wen_i(wen), .be_i(be), .data_i(data),
    .r_data_o(r_data), .r_valid_o(r_valid), .r_ready_i(r_ready), .n_out_o(n_out)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [15:0] nl(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock of the reference model: sample at negedge, update at posedge
  task automatic cycle();
    bit pop, st;
    int w;
    if (rnd_ready) r_ready = 1'($urandom);
    @(negedge clk);
    st = stall_en && (lm[3:0] < stall_thr);
    pop = (q.size() > 0) && r_ready;
    eg = req && !rst && !st && (!wen || (q.size() - int'(pop)) < 4);
    if (req && !rst) begin reqs++; if (st) stalls++; end
    s_valid = r_valid;
    s_data = r_data;
    chk("gnt", gnt, eg);
    chk("r_valid", r_valid, q.size() > 0);
    chk("n_out", n_out, q.size());
    if (q.size() > 0) chk("r_data", r_data, q[0]);
    @(posedge clk);
    if (rst) begin
      lm = SEED;
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      w = (add / 16) % 4096;
      if (eg && wen) q.push_back(mm[w]);
      if (eg && !wen) for (int b = 0; b < 16; b++) if (be[b]) mm[w][8*b +: 8] = data[8*b +: 8];
      lm = nl(lm);
    end
    #1;
  endtask

  task automatic xfer(input bit w, input logic [31:0] a, input logic [127:0] d, input logic [15:0] b);
    n = 0;
    req = 1; wen = w; add = a; data = d; be = b;
    do begin cycle(); n++; end while (!eg && n < 200);
    req = 0;
    chk("xfer_granted", eg, 1);
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() > 0 && k < 100) begin cycle(); k++; end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    checks = 0; errors = 0; stalls = 0; reqs = 0; rnd_ready = 0;
    rst = 1; stall_en = 0; stall_thr = 0; req = 1; wen = 1; add = 0; be = '1; data = 0; r_ready = 1;
    lm = SEED;
    cycle(); cycle();
    chk("rst_r_data", r_data, 0);
    req = 0;
    rst = 0;
    // basic write then read, latency 1
    xfer(0, 32'h40, {4{32'hDEADBEEF}}, '1);
    xfer(1, 32'h40, 0, 0);
    chk("t1_grant_cycles", n, 1);
    cycle();
    chk("t1_valid_next", s_valid, 1);
    chk("t1_data", s_data, {4{32'hDEADBEEF}});
    drain();
    // partial byte-enable write
    xfer(0, 32'h80, '1, '1);
    xfer(0, 32'h80, {16{8'h11}}, 16'h000F);
    xfer(1, 32'h84, 0, 0);
    cycle();
    chk("t2_be", s_data, {{12{8'hFF}}, {4{8'h11}}});
    drain();
    for (int i = 0; i < 16; i++) xfer(0, i * 16, {$urandom, $urandom, $urandom, $urandom}, '1);
    // backpressure: 6 reads with r_ready low
    r_ready = 0; req = 1; wen = 1; g = 0;
    for (int k = 0; k < 10; k++) begin add = g * 16; cycle(); if (eg) g++; end
    chk("t3_grants_full", g, 4);
    chk("t3_n_out_full", n_out, 4);
    chk("t3_gnt_blocked", gnt, 0);
    saved = r_data;
    cycle();
    chk("t3_r_data_stable", r_data, saved);
    r_ready = 1;
    for (int k = 0; k < 20 && g < 6; k++) begin add = g * 16; cycle(); if (eg) g++; end
    req = 0;
    chk("t3_all_granted", g, 6);
    drain();
    // address wrap
    xfer(0, 4096 * 16 + 32'h10, {4{32'hCAFEF00D}}, '1);
    xfer(1, 32'h10, 0, 0);
    cycle();
    chk("t4_wrap", s_data, {4{32'hCAFEF00D}});
    drain();
    // random traffic with stalls
    stall_en = 1; stall_thr = 8; stalls = 0; reqs = 0; rnd_ready = 1;
    for (int i = 0; i < 1000; i++)
      xfer(1'($urandom), ($urandom & 32'hFFFF_0000) | ($urandom_range(0, 15) * 16) | $urandom_range(0, 15),
           {$urandom, $urandom, $urandom, $urandom}, 16'($urandom));
    rnd_ready = 0; r_ready = 1;
    drain();
    chk("t5_stall_rate", (stalls * 100 >= reqs * 35) && (stalls * 100 <= reqs * 65), 1);
    // reset with reads outstanding
    stall_en = 0; r_ready = 0;
    for (int i = 0; i < 3; i++) xfer(1, i * 16, 0, 0);
    cycle();
    chk("t6_n_out_3", n_out, 3);
    saved = mm[4];
    rst = 1;
    q.delete();
    lm = SEED;
    #1;
    chk("t6_rst_valid", r_valid, 0);
    chk("t6_rst_n_out", n_out, 0);
    cycle();
    rst = 0; r_ready = 1;
    xfer(1, 32'h40, 0, 0);
    cycle();
    chk("t6_preserved", s_data, saved);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
